pipeline_stall_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges three event sources into one set of

---
 rtl/pipeline_stall_ctrl_if.sv | 34 +++
 rtl/pipeline_stall_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The master side drives the hazard and event inputs; the slave side is the controller.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_branch_taken;
  logic             mem_access;
  logic             perf_clear;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_flush;
  logic             pipe_freeze;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_access, perf_clear,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze,
           ctrl_state, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_access, perf_clear,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, pipe_freeze,
           ctrl_state, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch squash,
// fixed-latency memory freeze FSM and two saturating performance counters.
module pipeline_stall_ctrl #(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int WC_W        = (MEM_WAIT_CYCLES < 4) ? 2 : $clog2(MEM_WAIT_CYCLES);
  localparam int WAIT_INIT_I = (MEM_WAIT_CYCLES == 0) ? 0 : MEM_WAIT_CYCLES - 1;
  localparam logic [WC_W-1:0] WAIT_INIT = WC_W'(WAIT_INIT_I);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic hz, mw, freeze;

  assign hz = bus.ex_MemRead && (bus.ex_rd != 5'd0) &&
              ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  assign mw = (state_q == RUN) && bus.mem_access && (MEM_WAIT_CYCLES != 0);
  assign freeze = mw || (state_q == WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          cnt_d   = WAIT_INIT;
          state_d = (MEM_WAIT_CYCLES == 1) ? RELEASE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WC_W'(1);
        if (cnt_q == WC_W'(1)) state_d = RELEASE;
      end
      // The op in MEM advances here; mem_access is deliberately not re-sampled.
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.pipe_freeze = 1'b0;
    if (reset) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (freeze) begin
      bus.pipe_freeze = 1'b1;
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
    end else if (bus.ex_branch_taken) begin
      // ID holds a wrong-path instruction, so squash beats the load-use bubble.
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (hz) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.perf_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!bus.pc_write && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
      if (bus.idex_flush && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
    end
  end

  assign bus.ctrl_state   = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule
